// File: rtl/mem_pkg.sv
// Shared memory-interface definitions: controller mode encodings and LSU state type.
// Used by lsu_mem_if, lsu_load_ext and mem_ctrl.
package mem_pkg;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned MODE_W = 2;

   localparam logic [MODE_W-1:0] MODE_NONE = 2'd0;
   localparam logic [MODE_W-1:0] MODE_16   = 2'd1;
   localparam logic [MODE_W-1:0] MODE_32   = 2'd2;
   localparam logic [MODE_W-1:0] MODE_8    = 2'd3;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BEAT2 = 2'd1,
      CAPT  = 2'd2,
      RESP  = 2'd3
   } lsu_state_t;

   // Replicate right-aligned store data across the 32-bit controller data bus
   function automatic logic [DATA_W-1:0] fmt_store(input logic [MODE_W-1:0] size,
                                                   input logic [DATA_W-1:0] wdata);
      logic [DATA_W-1:0] res;
      case (size)
         MODE_8:  res = {4{wdata[7:0]}};
         MODE_16: res = {2{wdata[15:0]}};
         default: res = wdata;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/lsu_load_ext.sv
// Combinational load-data extender: selects 8/16/32-bit result and sign/zero-extends it.
module lsu_load_ext
   import mem_pkg::*;
(
   input  logic [MODE_W-1:0] i_size,
   input  logic              i_signed,
   input  logic [DATA_W-1:0] i_raw,
   output logic [DATA_W-1:0] o_data_c
);

   always_comb begin
      o_data_c = i_raw;
      case (i_size)
         MODE_8:  o_data_c = {{24{i_signed & i_raw[7]}}, i_raw[7:0]};
         MODE_16: o_data_c = {{16{i_signed & i_raw[15]}}, i_raw[15:0]};
         default: o_data_c = i_raw;
      endcase
   end

endmodule

// File: rtl/lsu_mem_if.sv
// Load/store interface stage in front of mem_ctrl: one request in flight, one response pulse each.
// Optional macro LSU_MISALIGN_TRAP_EN turns misaligned 16/32-bit requests into error responses.
module lsu_mem_if
   import mem_pkg::*;
#(
   parameter  int unsigned MEM_DEPTH  = 2**12,
   localparam int unsigned ADDR_WIDTH = $clog2(MEM_DEPTH*2)
)(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_req_valid,
   output logic                  o_req_ready,
   input  logic                  i_req_we,
   input  logic [MODE_W-1:0]     i_req_size,
   input  logic                  i_req_signed,
   input  logic [ADDR_WIDTH-1:0] i_req_addr,
   input  logic [DATA_W-1:0]     i_req_wdata,
   output logic                  o_resp_valid,
   output logic [DATA_W-1:0]     o_resp_rdata,
   output logic                  o_resp_err,
   output logic [ADDR_WIDTH-1:0] o_mem_addr,
   output logic [DATA_W-1:0]     o_mem_wdata,
   output logic [MODE_W-1:0]     o_wr_mode,
   output logic [MODE_W-1:0]     o_rd_mode,
   input  logic [DATA_W-1:0]     i_mem_rdata
);

   lsu_state_t              r_state;
   logic                    r_we;
   logic [MODE_W-1:0]       r_size;
   logic                    r_signed;
   logic [ADDR_WIDTH-1:0]   r_mem_addr;
   logic [DATA_W-1:0]       r_mem_wdata;
   logic                    r_resp_valid;
   logic [DATA_W-1:0]       r_resp_rdata;
   logic                    r_resp_err;

   logic                    w_issue;
   logic                    w_misalign;
   logic                    w_err;
   logic                    w_mem_issue;
   logic [ADDR_WIDTH-1:0]   w_addr_fmt;
   logic [DATA_W-1:0]       w_wdata_fmt;
   logic [DATA_W-1:0]       w_load_data;

   // Alignment handling: trap misaligned requests, or silently drop addr[0] for 16/32-bit
   always_comb begin
`ifdef LSU_MISALIGN_TRAP_EN
      w_misalign = ((i_req_size == MODE_16) && i_req_addr[0]) ||
                   ((i_req_size == MODE_32) && (i_req_addr[1:0] != 2'b00));
      w_addr_fmt = i_req_addr;
`else
      w_misalign = 1'b0;
      w_addr_fmt = {i_req_addr[ADDR_WIDTH-1:1],
                    (i_req_size == MODE_8) ? i_req_addr[0] : 1'b0};
`endif
   end

   assign w_issue     = (r_state == IDLE) && i_req_valid && !rst;
   assign w_err       = (i_req_size == MODE_NONE) || w_misalign;
   assign w_mem_issue = w_issue && !w_err;
   assign w_wdata_fmt = fmt_store(i_req_size, i_req_wdata);

   // Controller-side outputs are live in the issue cycle, otherwise idle/held
   assign o_req_ready  = (r_state == IDLE) && !rst;
   assign o_wr_mode    = (w_mem_issue &&  i_req_we) ? i_req_size : MODE_NONE;
   assign o_rd_mode    = (w_mem_issue && !i_req_we) ? i_req_size : MODE_NONE;
   assign o_mem_addr   = w_mem_issue ? w_addr_fmt  : r_mem_addr;
   assign o_mem_wdata  = w_mem_issue ? w_wdata_fmt : r_mem_wdata;
   assign o_resp_valid = r_resp_valid;
   assign o_resp_rdata = r_resp_rdata;
   assign o_resp_err   = r_resp_err;

   lsu_load_ext u_load_ext (
      .i_size   (r_size),
      .i_signed (r_signed),
      .i_raw    (i_mem_rdata),
      .o_data_c (w_load_data)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= IDLE;
         r_we         <= 1'b0;
         r_size       <= MODE_NONE;
         r_signed     <= 1'b0;
         r_mem_addr   <= '0;
         r_mem_wdata  <= '0;
         r_resp_valid <= 1'b0;
         r_resp_rdata <= '0;
         r_resp_err   <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_issue) begin
                  r_we     <= i_req_we;
                  r_size   <= i_req_size;
                  r_signed <= i_req_signed;
                  if (w_err) begin
                     r_state      <= RESP;
                     r_resp_valid <= 1'b1;
                     r_resp_err   <= 1'b1;
                     r_resp_rdata <= '0;
                  end else begin
                     r_mem_addr  <= w_addr_fmt;
                     r_mem_wdata <= w_wdata_fmt;
                     r_state     <= (i_req_size == MODE_32) ? BEAT2 : CAPT;
                  end
               end
            end
            BEAT2: r_state <= CAPT;
            CAPT: begin
               r_state      <= RESP;
               r_resp_valid <= 1'b1;
               r_resp_err   <= 1'b0;
               r_resp_rdata <= r_we ? '0 : w_load_data;
            end
            RESP: begin
               r_state      <= IDLE;
               r_resp_valid <= 1'b0;
               r_resp_err   <= 1'b0;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_lsu_mem_if.sv
// Directed bench for lsu_mem_if: vector table of single transactions plus
// hand-written back-pressure and mid-operation reset sequences.
module tb_lsu_mem_if;

   localparam int unsigned AW = 13;

   logic          clk = 1'b0;
   logic          rst;
   logic          i_req_valid;
   logic          o_req_ready;
   logic          i_req_we;
   logic [1:0]    i_req_size;
   logic          i_req_signed;
   logic [AW-1:0] i_req_addr;
   logic [31:0]   i_req_wdata;
   logic          o_resp_valid;
   logic [31:0]   o_resp_rdata;
   logic          o_resp_err;
   logic [AW-1:0] o_mem_addr;
   logic [31:0]   o_mem_wdata;
   logic [1:0]    o_wr_mode;
   logic [1:0]    o_rd_mode;
   logic [31:0]   i_mem_rdata;

   int n_pass  = 0;
   int n_total = 0;

   localparam logic [31:0] FILL = 32'hA5A5_A5A5;

   lsu_mem_if #(.MEM_DEPTH(4096)) dut (
      .clk          (clk),
      .rst          (rst),
      .i_req_valid  (i_req_valid),
      .o_req_ready  (o_req_ready),
      .i_req_we     (i_req_we),
      .i_req_size   (i_req_size),
      .i_req_signed (i_req_signed),
      .i_req_addr   (i_req_addr),
      .i_req_wdata  (i_req_wdata),
      .o_resp_valid (o_resp_valid),
      .o_resp_rdata (o_resp_rdata),
      .o_resp_err   (o_resp_err),
      .o_mem_addr   (o_mem_addr),
      .o_mem_wdata  (o_mem_wdata),
      .o_wr_mode    (o_wr_mode),
      .o_rd_mode    (o_rd_mode),
      .i_mem_rdata  (i_mem_rdata)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic          we;
      logic [1:0]    size;
      logic          sgn;
      logic [AW-1:0] addr;
      logic [31:0]   wdata;
      logic [31:0]   raw;
      logic [1:0]    exp_wr;
      logic [1:0]    exp_rd;
      logic          chk_addr;
      logic [AW-1:0] exp_addr;
      logic [31:0]   exp_wdata;
      int            lat;
      logic [31:0]   exp_rdata;
      logic          exp_err;
   } vec_t;

   vec_t vecs[13];

   function automatic vec_t mk(input logic we, input logic [1:0] size, input logic sgn,
                               input logic [AW-1:0] addr, input logic [31:0] wdata,
                               input logic [31:0] raw, input logic [1:0] exp_wr,
                               input logic [1:0] exp_rd, input logic chk_addr,
                               input logic [AW-1:0] exp_addr, input logic [31:0] exp_wdata,
                               input int lat, input logic [31:0] exp_rdata,
                               input logic exp_err);
      vec_t v;
      v.we = we; v.size = size; v.sgn = sgn; v.addr = addr; v.wdata = wdata; v.raw = raw;
      v.exp_wr = exp_wr; v.exp_rd = exp_rd; v.chk_addr = chk_addr; v.exp_addr = exp_addr;
      v.exp_wdata = exp_wdata; v.lat = lat; v.exp_rdata = exp_rdata; v.exp_err = exp_err;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic set_req(input logic we, input logic [1:0] size, input logic sgn,
                          input logic [AW-1:0] addr, input logic [31:0] wdata);
      i_req_valid = 1'b1; i_req_we = we; i_req_size = size;
      i_req_signed = sgn; i_req_addr = addr; i_req_wdata = wdata;
   endtask

   // One full transaction: issue-cycle checks, per-cycle checks until the response
   task automatic run_vec(input vec_t v, input int idx);
      @(posedge clk); #1;
      set_req(v.we, v.size, v.sgn, v.addr, v.wdata);
      i_mem_rdata = FILL;
      @(negedge clk);
      chk($sformatf("v%0d_issue_ready", idx), 32'(o_req_ready), 32'd1);
      chk($sformatf("v%0d_wr_mode", idx), 32'(o_wr_mode), 32'(v.exp_wr));
      chk($sformatf("v%0d_rd_mode", idx), 32'(o_rd_mode), 32'(v.exp_rd));
      if (v.chk_addr) chk($sformatf("v%0d_mem_addr", idx), 32'(o_mem_addr), 32'(v.exp_addr));
      if (v.we) chk($sformatf("v%0d_mem_wdata", idx), o_mem_wdata, v.exp_wdata);
      @(posedge clk); #1;
      i_req_valid = 1'b0;
      for (int k = 1; k <= v.lat; k++) begin
         i_mem_rdata = (k == v.lat - 1) ? v.raw : FILL;
         @(negedge clk);
         chk($sformatf("v%0d_c%0d_ready", idx, k), 32'(o_req_ready), 32'd0);
         chk($sformatf("v%0d_c%0d_modes", idx, k), 32'({o_wr_mode, o_rd_mode}), 32'd0);
         chk($sformatf("v%0d_c%0d_resp_valid", idx, k), 32'(o_resp_valid), 32'(k == v.lat));
         if (k == 1 && v.chk_addr)
            chk($sformatf("v%0d_addr_held", idx), 32'(o_mem_addr), 32'(v.exp_addr));
         if (k == 1 && v.we)
            chk($sformatf("v%0d_wdata_held", idx), o_mem_wdata, v.exp_wdata);
         if (k == v.lat) begin
            chk($sformatf("v%0d_rdata", idx), o_resp_rdata, v.exp_rdata);
            chk($sformatf("v%0d_err", idx), 32'(o_resp_err), 32'(v.exp_err));
         end
         @(posedge clk); #1;
      end
      i_mem_rdata = FILL;
      @(negedge clk);
      chk($sformatf("v%0d_back_idle", idx), 32'(o_req_ready), 32'd1);
      chk($sformatf("v%0d_resp_done", idx), 32'(o_resp_valid), 32'd0);
   endtask

   initial begin
      //                we    size  sgn  addr       wdata          raw            wr    rd    ca  exp_addr   exp_wdata      lat rdata          err
      vecs[0]  = mk(1'b1, 2'd2, 1'b0, 13'h010,  32'hDEADBEEF, FILL,          2'd2, 2'd0, 1, 13'h010,  32'hDEADBEEF, 3, 32'h0,         1'b0);
      vecs[1]  = mk(1'b0, 2'd3, 1'b1, 13'h011,  32'h0,        32'h00000080,  2'd0, 2'd3, 1, 13'h011,  32'h0,        2, 32'hFFFFFF80,  1'b0);
      vecs[2]  = mk(1'b0, 2'd3, 1'b0, 13'h011,  32'h0,        32'h00000080,  2'd0, 2'd3, 1, 13'h011,  32'h0,        2, 32'h00000080,  1'b0);
      vecs[3]  = mk(1'b0, 2'd1, 1'b1, 13'h020,  32'h0,        32'h00007FFF,  2'd0, 2'd1, 1, 13'h020,  32'h0,        2, 32'h00007FFF,  1'b0);
      vecs[4]  = mk(1'b0, 2'd1, 1'b1, 13'h020,  32'h0,        32'h0000C000,  2'd0, 2'd1, 1, 13'h020,  32'h0,        2, 32'hFFFFC000,  1'b0);
      vecs[5]  = mk(1'b0, 2'd2, 1'b1, 13'h020,  32'h0,        32'h12345678,  2'd0, 2'd2, 1, 13'h020,  32'h0,        3, 32'h12345678,  1'b0);
      vecs[6]  = mk(1'b1, 2'd3, 1'b0, 13'h005,  32'h123456AB, FILL,          2'd3, 2'd0, 1, 13'h005,  32'hABABABAB, 2, 32'h0,         1'b0);
      vecs[7]  = mk(1'b1, 2'd1, 1'b0, 13'h006,  32'h1234BEEF, FILL,          2'd1, 2'd0, 1, 13'h006,  32'hBEEFBEEF, 2, 32'h0,         1'b0);
      vecs[8]  = mk(1'b0, 2'd1, 1'b0, 13'h008,  32'h0,        32'hFFFF8001,  2'd0, 2'd1, 1, 13'h008,  32'h0,        2, 32'h00008001,  1'b0);
      vecs[9]  = mk(1'b0, 2'd0, 1'b1, 13'h040,  32'h0,        FILL,          2'd0, 2'd0, 0, 13'h000,  32'h0,        1, 32'h0,         1'b1);
`ifdef LSU_MISALIGN_TRAP_EN
      vecs[10] = mk(1'b0, 2'd1, 1'b1, 13'h003,  32'h0,        32'h00008000,  2'd0, 2'd0, 0, 13'h000,  32'h0,        1, 32'h0,         1'b1);
      vecs[11] = mk(1'b0, 2'd2, 1'b0, 13'h00F,  32'h0,        32'hCAFEF00D,  2'd0, 2'd0, 0, 13'h000,  32'h0,        1, 32'h0,         1'b1);
`else
      vecs[10] = mk(1'b0, 2'd1, 1'b1, 13'h003,  32'h0,        32'h00008000,  2'd0, 2'd1, 1, 13'h002,  32'h0,        2, 32'hFFFF8000,  1'b0);
      vecs[11] = mk(1'b0, 2'd2, 1'b0, 13'h00F,  32'h0,        32'hCAFEF00D,  2'd0, 2'd2, 1, 13'h00E,  32'h0,        3, 32'hCAFEF00D,  1'b0);
`endif
      vecs[12] = mk(1'b0, 2'd3, 1'b1, 13'h1FFF, 32'h0,        32'h0000007F,  2'd0, 2'd3, 1, 13'h1FFF, 32'h0,        2, 32'h0000007F,  1'b0);

      // Reset with a request pending: nothing may be accepted or driven
      rst = 1'b1;
      set_req(1'b0, 2'd1, 1'b0, 13'h004, 32'h0);
      i_mem_rdata = FILL;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_ready", 32'(o_req_ready), 32'd0);
      chk("rst_modes", 32'({o_wr_mode, o_rd_mode}), 32'd0);
      chk("rst_resp_valid", 32'(o_resp_valid), 32'd0);
      chk("rst_resp_rdata", o_resp_rdata, 32'd0);
      chk("rst_resp_err", 32'(o_resp_err), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      i_req_valid = 1'b0;
      @(negedge clk);
      chk("post_rst_ready", 32'(o_req_ready), 32'd1);

      for (int i = 0; i < 13; i++) run_vec(vecs[i], i);

      // 32-bit load with a second request held valid: accepted only at T+4
      @(posedge clk); #1;
      set_req(1'b0, 2'd2, 1'b0, 13'h020, 32'h0);
      @(negedge clk);
      chk("bp_issue_rd", 32'(o_rd_mode), 32'd2);
      @(posedge clk); #1;
      set_req(1'b0, 2'd3, 1'b0, 13'h030, 32'h0);
      for (int k = 1; k <= 3; k++) begin
         i_mem_rdata = (k == 2) ? 32'h11223344 : FILL;
         @(negedge clk);
         chk($sformatf("bp_c%0d_ready", k), 32'(o_req_ready), 32'd0);
         chk($sformatf("bp_c%0d_rd_mode", k), 32'(o_rd_mode), 32'd0);
         chk($sformatf("bp_c%0d_resp_valid", k), 32'(o_resp_valid), 32'(k == 3));
         if (k == 3) chk("bp_rdata", o_resp_rdata, 32'h11223344);
         @(posedge clk); #1;
      end
      i_mem_rdata = FILL;
      @(negedge clk);
      chk("bp_t4_ready", 32'(o_req_ready), 32'd1);
      chk("bp_t4_rd_mode", 32'(o_rd_mode), 32'd3);
      chk("bp_t4_addr", 32'(o_mem_addr), 32'h030);
      @(posedge clk); #1;
      i_req_valid = 1'b0;
      i_mem_rdata = 32'hFFFFFFC3;
      @(negedge clk);
      @(posedge clk); #1;
      i_mem_rdata = FILL;
      @(negedge clk);
      chk("bp2_resp_valid", 32'(o_resp_valid), 32'd1);
      chk("bp2_rdata", o_resp_rdata, 32'h000000C3);

      // Reset during BEAT2 of a 32-bit load: no response, back to IDLE
      @(posedge clk); #1;
      set_req(1'b0, 2'd2, 1'b1, 13'h040, 32'h0);
      @(negedge clk);
      chk("mr_issue_rd", 32'(o_rd_mode), 32'd2);
      @(posedge clk); #1;
      rst = 1'b1;
      @(negedge clk);
      chk("mr_rst_ready", 32'(o_req_ready), 32'd0);
      chk("mr_rst_modes", 32'({o_wr_mode, o_rd_mode}), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      i_req_valid = 1'b0;
      i_mem_rdata = 32'h87654321;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk($sformatf("mr_idle_%0d_ready", k), 32'(o_req_ready), 32'd1);
         chk($sformatf("mr_idle_%0d_resp", k), 32'(o_resp_valid), 32'd0);
         @(posedge clk); #1;
      end
      run_vec(vecs[5], 100);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/lsu_mem_if.md
Name: lsu_mem_if

Overview:
Load/store interface stage sitting directly upstream of the halfword memory controller (mem_ctrl). It accepts one load/store request at a time from the CPU execute stage and converts it to the controller's wr_mode/rd_mode protocol. It holds off new requests during the 32-bit second beat, samples controller read data at the correct cycle, and sign- or zero-extends it. Each accepted request produces exactly one registered response pulse.

Parameters:
MEM_DEPTH, 2**12, number of 16-bit halfwords in memory; must match mem_ctrl
ADDR_WIDTH, $clog2(MEM_DEPTH*2), localparam; byte-address width (13 at default)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
i_req_valid  in  1  request present
o_req_ready  out  1  request accepted when valid&ready
i_req_we  in  1  1=store, 0=load
i_req_size  in  2  MODE_16=1, MODE_32=2, MODE_8=3; MODE_NONE=0 is illegal and treated as a misaligned/error request
i_req_signed  in  1  loads: sign-extend 8/16-bit result
i_req_addr  in  ADDR_WIDTH  byte address
i_req_wdata  in  32  store data, right-aligned
o_resp_valid  out  1  one-cycle pulse, response ready
o_resp_rdata  out  32  extended load data; 0 for stores/errors
o_resp_err  out  1  valid with o_resp_valid; misaligned/illegal request
o_mem_addr  out  ADDR_WIDTH  to controller i_cpu_addr
o_mem_wdata  out  32  to controller i_cpu_data
o_wr_mode  out  2  to controller i_wr_mode
o_rd_mode  out  2  to controller i_rd_mode
i_mem_rdata  in  32  from controller o_cpu_data

Behaviour:
- Clock and reset: clk; rst is synchronous, active-high.
- States: IDLE, BEAT2, CAPT, RESP.
- Reset state and values: state=IDLE; o_resp_valid=0; o_resp_rdata=0; o_resp_err=0. While rst=1, o_wr_mode=o_rd_mode=MODE_NONE and o_req_ready=0.
- o_req_ready is 1 only in IDLE and not in reset.
- Issue cycle T (IDLE, i_req_valid=1, request legal):
  - Stores drive o_wr_mode=i_req_size; loads drive o_rd_mode=i_req_size. The other mode is MODE_NONE.
  - o_mem_addr=i_req_addr; both mode outputs are combinational from the request.
  - 32-bit requests go to BEAT2; 8/16-bit requests go to CAPT.
- In every non-issue cycle, both modes are MODE_NONE and o_mem_addr holds the last issued address (registered).
- Store data formatting:
  - MODE_8: o_mem_wdata={4{wdata[7:0]}}.
  - MODE_16: {2{wdata[15:0]}}.
  - MODE_32: wdata unchanged.
  - Held registered after the issue cycle.
- Transitions:
  - BEAT2 (T+1): the controller performs its upper-halfword access; go to CAPT.
  - CAPT: for loads, sample i_mem_rdata (8/16-bit at T+1, 32-bit at T+2); go to RESP.
  - RESP: o_resp_valid=1 for one cycle; go to IDLE.
- Load data extension:
  - MODE_8: low 8 bits, sign- or zero-extended per i_req_signed.
  - MODE_16: low 16 bits, extended the same way.
  - MODE_32: all 32 bits passed through.
  - i_req_signed is captured at issue.
- Response latency: 8/16-bit = 2 cycles after issue; 32-bit = 3 cycles after issue.
- Minimum spacing between accepts: 3 cycles (8/16-bit), 4 cycles (32-bit).
- Stores also pulse o_resp_valid, with o_resp_rdata=0.
- Illegal request (size=0, or misaligned when the trap is enabled): no memory mode driven; go directly to RESP with o_resp_err=1.
- Request inputs may change freely while not ready; they are ignored.
- Reset mid-operation (any state): return to IDLE next cycle, no response issued, modes forced to MODE_NONE in the reset cycle.
- Address wrap: the 32-bit upper halfword at the top address wraps modulo 2**ADDR_WIDTH inside the controller. This block does not check it.

Optional Feature:
LSU_MISALIGN_TRAP_EN
- Defined: MODE_16 with addr[0]=1, or MODE_32 with addr[1:0]!=0, is rejected with o_resp_err=1 and no memory access.
- Undefined: addr[0] is forced to 0 for 16/32-bit accesses, addr[1] is untouched, and o_resp_err is tied 0 except for size=0.

Decomposition:
- Shared package mem_pkg:
  - mode constants MODE_NONE/MODE_16/MODE_32/MODE_8 (2-bit), also used by mem_ctrl;
  - lsu_state_t enum.
- One natural sub-module: lsu_load_ext, a combinational extend/format unit (size, signed, raw -> 32-bit).

Test Plan:
1. Store MODE_32 addr 0x010 data 0xDEADBEEF -> T: wr_mode=2, addr=0x010; ready=0 at T+1..T+2; resp_valid at T+3, err=0, rdata=0.
2. Load MODE_8 signed addr 0x011, i_mem_rdata=0x00000080 at T+1 -> resp at T+2, rdata=0xFFFFFF80; unsigned repeat -> 0x00000080.
3. Load MODE_16 signed, i_mem_rdata=0x00007FFF -> rdata=0x00007FFF; with 0x0000C000 -> 0xFFFFC000.
4. Load MODE_32 addr 0x020, i_mem_rdata=0x12345678 at T+2 -> resp at T+3, rdata=0x12345678; a req_valid held at T+1..T+2 is not accepted until T+4.
5. MODE_16 at addr 0x003:
   - with LSU_MISALIGN_TRAP_EN: no mode driven, resp at T+1 with err=1;
   - without it: o_mem_addr=0x002, err=0.
6. rst asserted in BEAT2 of a 32-bit load -> next cycle IDLE, no resp_valid pulse, modes=0; a new request after rst completes normally.
